mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory bus between the pipeline's instruction-fetch requester (IF) and its load/store requester (MEM/LSU). Only one transaction is in flight at a time. Data requests normally take priority, and a run-length counter guarantees fetch progress. The block produces per-requester stall signals for the hazard unit and drops fetch responses that a branch flush has made obsolete. It sits between the IF/MEM stages and the memory bus.

## Interface
- MAX_DM_RUN, 4: maximum consecutive DM grants while IF is requesting; legal range 1..15.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_if_req  in  1  fetch request; level, held until o_if_valid or withdrawn by flush.
- i_if_addr  in  32  fetch address; stable while i_if_req is high.
- o_if_valid  out  1  fetch response strobe, one cycle.
- o_if_rdata  out  32  fetch data; valid only with o_if_valid.
- o_if_stall  out  1  i_if_req & ~o_if_valid.
- i_flush  in  1  branch taken; cancels any pending or outstanding fetch.
- i_dm_req  in  1  data request; level, held until o_dm_valid.
- i_dm_wren  in  1  1 = store, 0 = load.
- i_dm_addr  in  32  data address.
- i_dm_wdata  in  32  store data.
- i_dm_bmask  in  4  store byte enables.
- o_dm_valid  out  1  data response strobe (load data or store ack), one cycle.
- o_dm_rdata  out  32  load data.
- o_dm_stall  out  1  i_dm_req & ~o_dm_valid.
- o_bus_req  out  1  bus request; registered.
- o_bus_wren, o_bus_addr[31:0], o_bus_wdata[31:0], o_bus_bmask[3:0]  out  registered copies of the granted request.
- i_bus_gnt  in  1  bus accepts the request in the cycle where o_bus_req & i_bus_gnt.
- i_bus_rvalid  in  1  response or write ack, one cycle.
- i_bus_rdata  in  32  response data.
- o_busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: o_bus_req held until grant.
  - WAIT: awaiting i_bus_rvalid.
- Owner register: IF or DM, latched when the FSM leaves IDLE.
- Arbitration in IDLE:
  - Candidates are dm = i_dm_req and ifc = i_if_req & ~i_flush.
  - IF wins if ifc & (~dm | dm_run == MAX_DM_RUN). Otherwise DM wins if dm.
  - With no candidate, the FSM stays in IDLE.
- dm_run counter (4 bits):
  - +1 on each DM grant, saturating at MAX_DM_RUN.
  - Cleared on each IF grant.
  - Unchanged while IF is not requesting, so DM may issue indefinitely when IF is idle.
- On a grant: load the bus output registers from the winner (for IF: wren=0, bmask=0, wdata=0), then go to REQ.
- REQ:
  - On i_bus_gnt, drop o_bus_req and go to WAIT.
  - If owner=IF and i_flush, withdraw: o_bus_req=0 next cycle, back to IDLE. Withdrawal is legal only before grant.
  - Flush has no effect on a DM owner.
- WAIT:
  - On i_bus_rvalid, go to IDLE.
  - Response passthrough (combinational): o_x_valid = (state==WAIT) & i_bus_rvalid & (owner==x) & ~(x==IF & drop_q); o_x_rdata = i_bus_rdata.
  - drop_q is set by i_flush in WAIT while owner=IF, and also by i_flush in the same cycle as the rvalid. It is cleared when returning to IDLE.
- i_bus_rvalid outside WAIT is ignored (covers stale responses after reset).
- Because responses are combinational, a requester sees valid and may present its next request the following cycle without a duplicate issue.

## Timing
- Reset values:
  - state=IDLE, owner=IF, dm_run=0, drop_q=0.
  - o_bus_req=0, o_bus_wren=0, o_bus_addr=0, o_bus_wdata=0, o_bus_bmask=0.
  - o_busy=0.
  - o_if_valid=o_dm_valid=0; rdata outputs are don't-care.
- Reset mid-transaction: the FSM returns to IDLE immediately and o_bus_req drops the next cycle. Any in-flight response is ignored.
- Latency, with the request sampled in IDLE at cycle 0:
  - o_bus_req=1 at cycle 1.
  - Grant at cycle 1 (zero wait) means WAIT at cycle 2.
  - Earliest rvalid, and therefore the response strobe, at cycle 2.
  - Back in IDLE at cycle 3, which is also the earliest next arbitration.
  - Minimum issue interval: 3 cycles.
- An rvalid in the same cycle as the grant is ignored; the bus guarantees rvalid ≥1 cycle after grant.
- Simultaneous i_if_req and i_dm_req in IDLE: DM wins unless dm_run==MAX_DM_RUN.
- Flush coinciding with an IF grant in IDLE: IF is not a candidate, so DM or nothing is granted.

## Test plan
- Single load: i_dm_req with addr 0x100, bus grants at cycle 1 and rvalid at cycle 2 with 0xDEADBEEF -> o_bus_req high only in cycle 1, o_dm_valid=1 with rdata 0xDEADBEEF at cycle 2, o_dm_stall=1 in cycles 0-1.
- Contention fairness: i_dm_req and i_if_req held high continuously, MAX_DM_RUN=4, zero-wait bus -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Store: wren=1, addr 0x40, wdata 0x1234, bmask 0b0011 -> bus registers carry exactly these values, and o_dm_valid pulses on the ack.
- Flush before grant: IF granted, i_bus_gnt held low, i_flush asserted in REQ -> o_bus_req drops next cycle, FSM returns to IDLE, no o_if_valid.
- Flush in WAIT: IF outstanding, i_flush one cycle, rvalid two cycles later -> o_if_valid stays 0, FSM returns to IDLE, drop_q cleared.
- Reset mid-WAIT: i_rst during WAIT, then a stale rvalid after reset -> all outputs at their reset values, no valid strobe, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory bus between the instruction-fetch requester
// (IF) and the load/store requester (DM). Only one bus transaction is in
// flight at a time. DM normally wins arbitration, but a run-length counter
// forces an IF grant after MAX_DM_RUN consecutive DM grants while IF waits.
// Fetch responses made obsolete by a branch flush are swallowed.
//
// Parameters:
//   MAX_DM_RUN    consecutive DM grants allowed while IF is requesting (1..15)
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_req, i_if_addr       fetch request (level) and address
//   o_if_valid, o_if_rdata    fetch response strobe and data
//   o_if_stall                fetch stall for the hazard unit
//   i_flush                   branch taken; cancels pending/outstanding fetch
//   i_dm_req, i_dm_wren,      data request (level), store flag, address,
//   i_dm_addr, i_dm_wdata,    store data and byte enables
//   i_dm_bmask
//   o_dm_valid, o_dm_rdata    data response strobe (load data / store ack)
//   o_dm_stall                data stall for the hazard unit
//   o_bus_req, o_bus_wren,    registered bus request and copies of the
//   o_bus_addr, o_bus_wdata,  granted request
//   o_bus_bmask
//   i_bus_gnt                 bus accepts request when o_bus_req & i_bus_gnt
//   i_bus_rvalid, i_bus_rdata bus response / write ack and data
//   o_busy                    FSM is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_stall,
  input  logic        i_flush,
  input  logic        i_dm_req,
  input  logic        i_dm_wren,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_bmask,
  output logic        o_dm_valid,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_stall,
  output logic        o_bus_req,
  output logic        o_bus_wren,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_bmask,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

  state_t     state;
  logic       owner_dm;
  logic [3:0] dm_run;
  logic       drop_q;

  logic ifc_cand;
  logic dm_cand;
  logic grant_if;
  logic grant_dm;
  logic resp_here;

  // A flushed fetch is not a candidate. IF wins when DM is absent or when
  // DM has used up its run budget; otherwise DM takes the bus.
  always_comb begin
    ifc_cand = i_if_req & ~i_flush;
    dm_cand  = i_dm_req;
    grant_if = ifc_cand & (~dm_cand | (dm_run == RUN_MAX));
    grant_dm = dm_cand & ~grant_if;
  end

  // Arbitration FSM plus the registered bus request. The bus registers keep
  // the last granted request after the transaction completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      dm_run      <= 4'd0;
      drop_q      <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_wren  <= 1'b0;
      o_bus_addr  <= 32'd0;
      o_bus_wdata <= 32'd0;
      o_bus_bmask <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            state       <= REQ;
            owner_dm    <= 1'b0;
            dm_run      <= 4'd0;
            o_bus_req   <= 1'b1;
            o_bus_wren  <= 1'b0;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= 32'd0;
            o_bus_bmask <= 4'd0;
          end else if (grant_dm) begin
            state       <= REQ;
            owner_dm    <= 1'b1;
            o_bus_req   <= 1'b1;
            o_bus_wren  <= i_dm_wren;
            o_bus_addr  <= i_dm_addr;
            o_bus_wdata <= i_dm_wdata;
            o_bus_bmask <= i_dm_bmask;
            // The run only counts against IF while IF is actually waiting,
            // so DM can stream freely when fetch is quiet.
            if (i_if_req && (dm_run != RUN_MAX)) begin
              dm_run <= dm_run + 4'd1;
            end
          end
        end
        REQ: begin
          if (i_bus_gnt) begin
            state     <= WAIT;
            o_bus_req <= 1'b0;
            // A flush landing on the grant cycle can no longer withdraw the
            // request, so the eventual fetch response is dropped instead.
            if (!owner_dm && i_flush) begin
              drop_q <= 1'b1;
            end
          end else if (!owner_dm && i_flush) begin
            state     <= IDLE;
            o_bus_req <= 1'b0;
          end
        end
        WAIT: begin
          if (i_bus_rvalid) begin
            state  <= IDLE;
            drop_q <= 1'b0;
          end else if (!owner_dm && i_flush) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Responses pass straight through so a requester can issue its next
  // request in the cycle after it sees valid. A flush in the response cycle
  // itself masks the fetch strobe just like an earlier flush.
  always_comb begin
    resp_here  = (state == WAIT) & i_bus_rvalid;
    o_if_valid = resp_here & ~owner_dm & ~drop_q & ~i_flush;
    o_dm_valid = resp_here & owner_dm;
    o_if_rdata = i_bus_rdata;
    o_dm_rdata = i_bus_rdata;
    o_if_stall = i_if_req & ~o_if_valid;
    o_dm_stall = i_dm_req & ~o_dm_valid;
    o_busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter (MAX_DM_RUN = 4). A small bus model answers
// requests with zero wait states and data derived from the bus address; the
// expected response of every issued request is queued and matched against
// the response strobes as they appear. Multi-cycle corner cases (flush,
// reset mid-transaction) drive the bus by hand.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        o_if_stall;
  logic        i_flush;
  logic        i_dm_req;
  logic        i_dm_wren;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_bmask;
  logic        o_dm_valid;
  logic [31:0] o_dm_rdata;
  logic        o_dm_stall;
  logic        o_bus_req;
  logic        o_bus_wren;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_bmask;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        o_busy;

  mem_port_arbiter #(.MAX_DM_RUN(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_valid   (o_if_valid),
    .o_if_rdata   (o_if_rdata),
    .o_if_stall   (o_if_stall),
    .i_flush      (i_flush),
    .i_dm_req     (i_dm_req),
    .i_dm_wren    (i_dm_wren),
    .i_dm_addr    (i_dm_addr),
    .i_dm_wdata   (i_dm_wdata),
    .i_dm_bmask   (i_dm_bmask),
    .o_dm_valid   (o_dm_valid),
    .o_dm_rdata   (o_dm_rdata),
    .o_dm_stall   (o_dm_stall),
    .o_bus_req    (o_bus_req),
    .o_bus_wren   (o_bus_wren),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_bmask  (o_bus_bmask),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic        dm;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        exp_wren;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_bmask;
  } vec_t;

  typedef struct {
    logic        dm;
    logic [31:0] data;
  } exp_t;

  localparam logic [31:0] IF_A = 32'h0000_2000;
  localparam logic [31:0] DM_A = 32'h0000_3000;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  // Bus model controls: auto mode grants immediately and answers one cycle
  // after the grant; manual mode lets the test drive the bus directly.
  logic        bus_auto;
  logic        man_gnt;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        auto_gnt;
  logic        auto_rvalid;
  logic [31:0] auto_rdata;
  logic        granted;
  logic [31:0] granted_addr;

  assign i_bus_gnt    = bus_auto ? auto_gnt    : man_gnt;
  assign i_bus_rvalid = bus_auto ? auto_rvalid : man_rvalid;
  assign i_bus_rdata  = bus_auto ? auto_rdata  : man_rdata;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] resp_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  // Zero-wait memory model driven just after each rising edge.
  initial begin
    auto_gnt     = 1'b0;
    auto_rvalid  = 1'b0;
    auto_rdata   = 32'd0;
    granted      = 1'b0;
    granted_addr = 32'd0;
    forever begin
      @(posedge i_clk);
      #1;
      auto_rvalid  = granted;
      auto_rdata   = granted ? resp_fn(granted_addr) : 32'd0;
      granted      = bus_auto & o_bus_req;
      granted_addr = o_bus_addr;
      auto_gnt     = o_bus_req;
    end
  end

  // Scoreboard: every response strobe must match the oldest queued request.
  always @(posedge i_clk) begin
    #3;
    if (o_if_valid || o_dm_valid) begin
      total++;
      if (o_if_valid && o_dm_valid) begin
        bad++;
        $display("[TB] FAIL dual_valid: got if=%b dm=%b want only one", o_if_valid, o_dm_valid);
      end else if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_valid: got if=%b dm=%b want no response", o_if_valid, o_dm_valid);
      end else begin
        mon_e = sb.pop_front();
        if ((mon_e.dm !== o_dm_valid) ||
            ((o_dm_valid ? o_dm_rdata : o_if_rdata) !== mon_e.data)) begin
          bad++;
          $display("[TB] FAIL response: got dm=%b data=%h want dm=%b data=%h",
                   o_dm_valid, (o_dm_valid ? o_dm_rdata : o_if_rdata), mon_e.dm, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      next_cycle();
      #3;
      n++;
    end
    check_output("drain", sb.size(), 0);
  endtask

  // One complete zero-wait transaction, checked cycle by cycle.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    next_cycle();
    if (v.dm) begin
      i_dm_req   = 1'b1;
      i_dm_wren  = v.wren;
      i_dm_addr  = v.addr;
      i_dm_wdata = v.wdata;
      i_dm_bmask = v.bmask;
    end else begin
      i_if_req   = 1'b1;
      i_if_addr  = v.addr;
      i_dm_wren  = v.wren;
      i_dm_addr  = ~v.addr;
      i_dm_wdata = v.wdata;
      i_dm_bmask = v.bmask;
    end
    e.dm   = v.dm;
    e.data = resp_fn(v.addr);
    sb.push_back(e);
    #3;
    check_output("c0_bus_req", o_bus_req, 0);
    check_output("c0_busy", o_busy, 0);
    check_output("c0_stall", v.dm ? o_dm_stall : o_if_stall, 1);
    next_cycle();
    #3;
    check_output("c1_bus_req", o_bus_req, 1);
    check_output("c1_bus_wren", o_bus_wren, v.exp_wren);
    check_output("c1_bus_addr", o_bus_addr, v.addr);
    check_output("c1_bus_wdata", o_bus_wdata, v.exp_wdata);
    check_output("c1_bus_bmask", o_bus_bmask, v.exp_bmask);
    check_output("c1_stall", v.dm ? o_dm_stall : o_if_stall, 1);
    next_cycle();
    #3;
    check_output("c2_valid", v.dm ? o_dm_valid : o_if_valid, 1);
    check_output("c2_stall", v.dm ? o_dm_stall : o_if_stall, 0);
    check_output("c2_bus_req", o_bus_req, 0);
    next_cycle();
    i_dm_req = 1'b0;
    i_if_req = 1'b0;
    #3;
    check_output("c3_busy", o_busy, 0);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    total      = 0;
    bad        = 0;
    i_rst      = 1'b1;
    i_if_req   = 1'b0;
    i_if_addr  = 32'd0;
    i_flush    = 1'b0;
    i_dm_req   = 1'b0;
    i_dm_wren  = 1'b0;
    i_dm_addr  = 32'd0;
    i_dm_wdata = 32'd0;
    i_dm_bmask = 4'd0;
    bus_auto   = 1'b1;
    man_gnt    = 1'b0;
    man_rvalid = 1'b0;
    man_rdata  = 32'd0;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'hCAFE_0001, 4'h0, 1'b0, 32'hCAFE_0001, 4'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234, 4'h3, 1'b1, 32'h0000_1234, 4'h3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0000_ABCD, 4'h5, 1'b0, 32'h0, 4'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0044, 32'h5678_9ABC, 4'hC, 1'b1, 32'h5678_9ABC, 4'hC};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'hFFFF_FFFF, 4'hF};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0001, 4'h1, 1'b0, 32'h0000_0001, 4'h1};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0204, 32'h8000_0001, 4'h8, 1'b1, 32'h8000_0001, 4'h8};

    // Reset state
    repeat (3) next_cycle();
    i_rst = 1'b0;
    #3;
    check_output("rst_bus_req", o_bus_req, 0);
    check_output("rst_bus_wren", o_bus_wren, 0);
    check_output("rst_bus_addr", o_bus_addr, 0);
    check_output("rst_bus_wdata", o_bus_wdata, 0);
    check_output("rst_bus_bmask", o_bus_bmask, 0);
    check_output("rst_busy", o_busy, 0);
    check_output("rst_if_valid", o_if_valid, 0);
    check_output("rst_dm_valid", o_dm_valid, 0);

    // Single transactions; the trailing DM-only run must not age the counter
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
    end

    // Contention: both held, grant order DM x4 then IF, twice
    next_cycle();
    i_if_req   = 1'b1;
    i_if_addr  = IF_A;
    i_dm_req   = 1'b1;
    i_dm_wren  = 1'b0;
    i_dm_addr  = DM_A;
    i_dm_wdata = 32'd0;
    i_dm_bmask = 4'd0;
    for (int k = 0; k < 10; k++) begin
      e.dm   = ((k % 5) != 4);
      e.data = resp_fn(e.dm ? DM_A : IF_A);
      sb.push_back(e);
    end
    wait_drain(60);
    next_cycle();
    i_if_req = 1'b0;
    i_dm_req = 1'b0;
    #3;
    next_cycle();
    #3;
    check_output("cont_idle", o_busy, 0);

    // Flush alongside IF in IDLE: IF is no candidate, nothing granted
    next_cycle();
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_6000;
    i_flush   = 1'b1;
    next_cycle();
    i_if_req = 1'b0;
    i_flush  = 1'b0;
    #3;
    check_output("flush_idle_busy", o_busy, 0);
    check_output("flush_idle_req", o_bus_req, 0);

    // Flush alongside IF and DM in IDLE: DM granted
    next_cycle();
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_6000;
    i_flush   = 1'b1;
    i_dm_req  = 1'b1;
    i_dm_wren = 1'b0;
    i_dm_addr = 32'h0000_7000;
    e.dm   = 1'b1;
    e.data = resp_fn(32'h0000_7000);
    sb.push_back(e);
    next_cycle();
    i_if_req = 1'b0;
    i_flush  = 1'b0;
    #3;
    check_output("flush_dm_addr", o_bus_addr, 32'h0000_7000);
    next_cycle();
    #3;
    check_output("flush_dm_valid", o_dm_valid, 1);
    next_cycle();
    i_dm_req = 1'b0;
    #3;
    check_output("flush_dm_idle", o_busy, 0);

    // Flush before grant: request withdrawn, stray rvalid ignored
    bus_auto = 1'b0;
    next_cycle();
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_5000;
    next_cycle();
    i_flush = 1'b1;
    #3;
    check_output("wd_req_up", o_bus_req, 1);
    next_cycle();
    i_if_req = 1'b0;
    i_flush  = 1'b0;
    #3;
    check_output("wd_req_down", o_bus_req, 0);
    check_output("wd_busy", o_busy, 0);
    next_cycle();
    man_rvalid = 1'b1;
    man_rdata  = 32'h1357_9BDF;
    #3;
    check_output("wd_stray_valid", o_if_valid, 0);
    next_cycle();
    man_rvalid = 1'b0;

    // Flush in WAIT: response two cycles later is dropped
    next_cycle();
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_5004;
    next_cycle();
    man_gnt = 1'b1;
    next_cycle();
    man_gnt  = 1'b0;
    i_flush  = 1'b1;
    i_if_req = 1'b0;
    #3;
    check_output("fw_busy_c2", o_busy, 1);
    next_cycle();
    i_flush = 1'b0;
    next_cycle();
    man_rvalid = 1'b1;
    man_rdata  = 32'h1111_2222;
    #3;
    check_output("fw_if_valid", o_if_valid, 0);
    check_output("fw_busy_c4", o_busy, 1);
    next_cycle();
    man_rvalid = 1'b0;
    #3;
    check_output("fw_idle", o_busy, 0);

    // Flush in the same cycle as the response
    next_cycle();
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_5008;
    next_cycle();
    man_gnt = 1'b1;
    next_cycle();
    man_gnt    = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'h3333_4444;
    i_flush    = 1'b1;
    #3;
    check_output("fs_if_valid", o_if_valid, 0);
    next_cycle();
    man_rvalid = 1'b0;
    i_flush    = 1'b0;
    i_if_req   = 1'b0;
    #3;
    check_output("fs_idle", o_busy, 0);

    // A normal fetch afterwards is delivered (drop flag cleared)
    bus_auto = 1'b1;
    next_cycle();
    v = '{1'b0, 1'b0, 32'h0000_500C, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0};
    apply_stimulus(v);

    // Reset during WAIT, then a stale response
    bus_auto = 1'b0;
    next_cycle();
    i_dm_req   = 1'b1;
    i_dm_wren  = 1'b1;
    i_dm_addr  = 32'h0000_8000;
    i_dm_wdata = 32'hAAAA_5555;
    i_dm_bmask = 4'hF;
    next_cycle();
    man_gnt = 1'b1;
    #3;
    check_output("rw_bus_wren", o_bus_wren, 1);
    next_cycle();
    man_gnt  = 1'b0;
    i_rst    = 1'b1;
    i_dm_req = 1'b0;
    #3;
    check_output("rw_busy_wait", o_busy, 1);
    next_cycle();
    i_rst      = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'hBAD0_BAD0;
    #3;
    check_output("rw_bus_req", o_bus_req, 0);
    check_output("rw_bus_wren0", o_bus_wren, 0);
    check_output("rw_bus_addr", o_bus_addr, 0);
    check_output("rw_bus_wdata", o_bus_wdata, 0);
    check_output("rw_bus_bmask", o_bus_bmask, 0);
    check_output("rw_busy", o_busy, 0);
    check_output("rw_dm_valid", o_dm_valid, 0);
    check_output("rw_if_valid", o_if_valid, 0);
    next_cycle();
    man_rvalid = 1'b0;
    bus_auto   = 1'b1;
    v = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0};
    apply_stimulus(v);

    next_cycle();
    #3;
    check_output("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
